// File: rtl/ram_pipe_be_if.sv
// Request/response bundle between a RAM client (master) and ram_pipe_be (slave).
// Latency: none, plain wires.
// Backpressure: none; the RAM accepts every request it is offered.
interface ram_pipe_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Read port
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;
  logic [DATA_W-1:0]   r_line;
  logic                r_rdy;
  logic                r_exc;
  // Write port
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_line;
  logic [DATA_W/8-1:0] w_be;
  logic                w_req;
  logic                w_rdy;
  logic                w_exc;
  // Fault capture
  logic [ADDR_W-1:0]   exc_addr;
  logic                exc_vld;
  logic                exc_clr;

  modport master (
    output r_addr, r_req, w_addr, w_line, w_be, w_req, exc_clr,
    input  r_line, r_rdy, r_exc, w_rdy, w_exc, exc_addr, exc_vld
  );

  modport slave (
    input  r_addr, r_req, w_addr, w_line, w_be, w_req, exc_clr,
    output r_line, r_rdy, r_exc, w_rdy, w_exc, exc_addr, exc_vld
  );
endinterface

// File: rtl/ram_pipe_be.sv
// Simple dual-port word RAM with byte enables, range exceptions and sticky fault capture.
// Latency: read data READ_LAT (1 or 2) cycles after accept; write ack/exception one cycle after the write edge.
// Backpressure: none; one read and one write are accepted on every clock edge.
module ram_pipe_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_pipe_be_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("ram_pipe_be: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("ram_pipe_be: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Request decode: full-width range compare, no address wrap.
  logic             r_oob;
  logic             w_oob;
  logic             r_fault;
  logic             w_fault;
  logic             w_acc;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;

  assign r_oob   = {1'b0, bus.r_addr} >= DEPTH_X;
  assign w_oob   = {1'b0, bus.w_addr} >= DEPTH_X;
  assign r_fault = bus.r_req & r_oob;
  assign w_fault = bus.w_req & w_oob;
  assign w_acc   = bus.w_req & ~w_oob;
  assign r_idx   = bus.r_addr[IDX_W-1:0];
  assign w_idx   = bus.w_addr[IDX_W-1:0];

  // Write-first: a same-edge write to the read address is merged into the read word.
  logic [DATA_W-1:0] rd_merged;
  always_comb begin
    rd_merged = mem[r_idx];
    if (w_acc && (w_idx == r_idx)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.w_be[i]) rd_merged[8*i +: 8] = bus.w_line[8*i +: 8];
      end
    end
  end

  // Array update; a write on an edge with reset asserted is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.w_be[i]) mem[w_idx][8*i +: 8] <= bus.w_line[8*i +: 8];
      end
    end
  end

  // Stage 1 next state: out-of-range reads return zero; data holds when idle.
  logic              s1_rdy_d, s1_exc_d;
  logic [DATA_W-1:0] s1_dat_d;
  logic              s1_rdy_q, s1_exc_q;
  logic [DATA_W-1:0] s1_dat_q;

  always_comb begin
    s1_rdy_d = bus.r_req & ~r_oob;
    s1_exc_d = r_fault;
    s1_dat_d = s1_dat_q;
    if (bus.r_req) s1_dat_d = r_oob ? '0 : rd_merged;
  end

  // Stage 1 registers: array read result plus valid/exception flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rdy_q <= 1'b0;
      s1_exc_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_rdy_q <= s1_rdy_d;
      s1_exc_q <= s1_exc_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              r_rdy_q, r_exc_q;
    logic [DATA_W-1:0] r_line_q;

    // Stage 2 is a pure register; data only moves when stage 1 presents a response.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdy_q  <= 1'b0;
        r_exc_q  <= 1'b0;
        r_line_q <= '0;
      end else begin
        r_rdy_q <= s1_rdy_q;
        r_exc_q <= s1_exc_q;
        if (s1_rdy_q || s1_exc_q) r_line_q <= s1_dat_q;
      end
    end

    assign bus.r_rdy  = r_rdy_q;
    assign bus.r_exc  = r_exc_q;
    assign bus.r_line = r_line_q;
  end else begin : g_lat1
    assign bus.r_rdy  = s1_rdy_q;
    assign bus.r_exc  = s1_exc_q;
    assign bus.r_line = s1_dat_q;
  end

  // Fault capture next state: first fault wins, read beats write, new fault beats clear.
  logic              exc_vld_d, exc_vld_q;
  logic [ADDR_W-1:0] exc_addr_d, exc_addr_q;

  always_comb begin
    exc_vld_d  = exc_vld_q;
    exc_addr_d = exc_addr_q;
    if ((r_fault || w_fault) && (!exc_vld_q || bus.exc_clr)) begin
      exc_vld_d  = 1'b1;
      exc_addr_d = r_fault ? bus.r_addr : bus.w_addr;
    end else if (bus.exc_clr) begin
      exc_vld_d  = 1'b0;
      exc_addr_d = '0;
    end
  end

  // Write response pulses and fault capture registers.
  logic w_rdy_q, w_exc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rdy_q    <= 1'b0;
      w_exc_q    <= 1'b0;
      exc_vld_q  <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      w_rdy_q    <= w_acc;
      w_exc_q    <= w_fault;
      exc_vld_q  <= exc_vld_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign bus.w_rdy    = w_rdy_q;
  assign bus.w_exc    = w_exc_q;
  assign bus.exc_vld  = exc_vld_q;
  assign bus.exc_addr = exc_addr_q;

endmodule

// File: tb/tb_ram_pipe_be.sv
// Directed bench for ram_pipe_be: one instance with 1-cycle reads, one with 2-cycle reads.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Both instances share clock and reset.
module tb_ram_pipe_be;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ram_pipe_be_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  ram_pipe_be_if #(.DATA_W(32), .ADDR_W(32)) if2 ();

  ram_pipe_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  ram_pipe_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if1.r_req = 0; if1.w_req = 0; if1.exc_clr = 0; if1.w_be = 4'h0;
    if2.r_req = 0; if2.w_req = 0; if2.exc_clr = 0; if2.w_be = 4'h0;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    if1.w_addr = a; if1.w_line = d; if1.w_be = 4'hF; if1.w_req = 1;
    cyc();
    if1.w_req = 0;
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    if2.w_addr = a; if2.w_line = d; if2.w_be = 4'hF; if2.w_req = 1;
    cyc();
    if2.w_req = 0;
  endtask

  task automatic test_reset();
    if1.r_addr = 0; if1.w_addr = 0; if1.w_line = 0;
    if2.r_addr = 0; if2.w_addr = 0; if2.w_line = 0;
    idle();
    rst_n = 0;
    cyc(); cyc();
    checks++; if (if1.r_line !== 32'h0) begin errors++; $display("FAIL rst_r_line1 got=%h exp=%h", if1.r_line, 32'h0); end
    checks++; if ({if1.r_rdy, if1.r_exc, if1.w_rdy, if1.w_exc, if1.exc_vld} !== 5'b0) begin errors++; $display("FAIL rst_flags1 got=%b exp=00000", {if1.r_rdy, if1.r_exc, if1.w_rdy, if1.w_exc, if1.exc_vld}); end
    checks++; if (if1.exc_addr !== 32'h0) begin errors++; $display("FAIL rst_exc_addr1 got=%h exp=%h", if1.exc_addr, 32'h0); end
    checks++; if ({if2.r_rdy, if2.r_exc, if2.w_rdy, if2.w_exc, if2.exc_vld} !== 5'b0) begin errors++; $display("FAIL rst_flags2 got=%b exp=00000", {if2.r_rdy, if2.r_exc, if2.w_rdy, if2.w_exc, if2.exc_vld}); end
    checks++; if (if2.r_line !== 32'h0) begin errors++; $display("FAIL rst_r_line2 got=%h exp=%h", if2.r_line, 32'h0); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_write_read();
    if1.w_addr = 5; if1.w_line = 32'hDEADBEEF; if1.w_be = 4'hF; if1.w_req = 1;
    cyc();
    if1.w_req = 0;
    checks++; if (if1.w_rdy !== 1'b1) begin errors++; $display("FAIL t1_w_rdy got=%b exp=1", if1.w_rdy); end
    checks++; if (if1.w_exc !== 1'b0) begin errors++; $display("FAIL t1_w_exc got=%b exp=0", if1.w_exc); end
    if1.r_addr = 5; if1.r_req = 1;
    cyc();
    if1.r_req = 0;
    checks++; if (if1.w_rdy !== 1'b0) begin errors++; $display("FAIL t1_w_rdy_pulse got=%b exp=0", if1.w_rdy); end
    checks++; if (if1.r_rdy !== 1'b1 || if1.r_exc !== 1'b0) begin errors++; $display("FAIL t1_r_rdy got=%b%b exp=10", if1.r_rdy, if1.r_exc); end
    checks++; if (if1.r_line !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_r_line got=%h exp=%h", if1.r_line, 32'hDEADBEEF); end
    cyc();
    checks++; if (if1.r_rdy !== 1'b0) begin errors++; $display("FAIL t1_r_rdy_pulse got=%b exp=0", if1.r_rdy); end
    checks++; if (if1.r_line !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_r_line_hold got=%h exp=%h", if1.r_line, 32'hDEADBEEF); end
  endtask

  task automatic test_write_first();
    wr1(7, 32'h11223344);
    if1.w_addr = 7; if1.w_line = 32'hAABBCCDD; if1.w_be = 4'b0101; if1.w_req = 1;
    if1.r_addr = 7; if1.r_req = 1;
    cyc();
    if1.w_req = 0;
    checks++; if (if1.r_rdy !== 1'b1 || if1.r_line !== 32'h11BB33DD) begin errors++; $display("FAIL t2_merge got=%b/%h exp=1/%h", if1.r_rdy, if1.r_line, 32'h11BB33DD); end
    // Byte enable zero: acknowledged, nothing changes.
    if1.w_addr = 7; if1.w_line = 32'hFFFFFFFF; if1.w_be = 4'h0; if1.w_req = 1;
    if1.r_req = 0;
    cyc();
    if1.w_req = 0;
    checks++; if (if1.w_rdy !== 1'b1) begin errors++; $display("FAIL t2_be0_w_rdy got=%b exp=1", if1.w_rdy); end
    if1.r_addr = 7; if1.r_req = 1;
    cyc();
    if1.r_req = 0;
    checks++; if (if1.r_line !== 32'h11BB33DD) begin errors++; $display("FAIL t2_reread got=%h exp=%h", if1.r_line, 32'h11BB33DD); end
    // Last in-range address.
    wr1(1023, 32'h0BADF00D);
    if1.r_addr = 1023; if1.r_req = 1;
    cyc();
    if1.r_req = 0;
    checks++; if (if1.r_rdy !== 1'b1 || if1.r_exc !== 1'b0 || if1.r_line !== 32'h0BADF00D) begin errors++; $display("FAIL t2_top_addr got=%b%b/%h exp=10/%h", if1.r_rdy, if1.r_exc, if1.r_line, 32'h0BADF00D); end
    checks++; if (if1.exc_vld !== 1'b0) begin errors++; $display("FAIL t2_no_fault got=%b exp=0", if1.exc_vld); end
  endtask

  task automatic test_pipeline();
    logic [31:0] exp_d;
    logic        exp_v;
    for (int a = 0; a < 4; a++) wr2(a, 32'h10 + a);
    for (int i = 0; i < 6; i++) begin
      if2.r_req = (i < 4); if2.r_addr = i;
      cyc();
      exp_v = (i >= 1 && i <= 4);
      exp_d = (i >= 1) ? 32'h10 + ((i > 4) ? 3 : i - 1) : 32'h0;
      checks++; if (if2.r_rdy !== exp_v) begin errors++; $display("FAIL t3_rdy_%0d got=%b exp=%b", i, if2.r_rdy, exp_v); end
      if (i >= 1) begin
        checks++; if (if2.r_line !== exp_d) begin errors++; $display("FAIL t3_data_%0d got=%h exp=%h", i, if2.r_line, exp_d); end
      end
    end
    // Out-of-range read through the two-stage pipe.
    if2.r_addr = 1024; if2.r_req = 1;
    cyc();
    if2.r_req = 0;
    checks++; if (if2.r_exc !== 1'b0) begin errors++; $display("FAIL t3_exc_early got=%b exp=0", if2.r_exc); end
    cyc();
    checks++; if (if2.r_exc !== 1'b1 || if2.r_rdy !== 1'b0 || if2.r_line !== 32'h0) begin errors++; $display("FAIL t3_exc got=%b%b/%h exp=10/0", if2.r_exc, if2.r_rdy, if2.r_line); end
    if2.exc_clr = 1;
    cyc();
    if2.exc_clr = 0;
  endtask

  task automatic test_faults();
    wr1(0, 32'hCAFEF00D);
    if1.r_addr = 1024; if1.r_req = 1;
    if1.w_addr = 32'h8000_0000; if1.w_line = 32'hFFFFFFFF; if1.w_be = 4'hF; if1.w_req = 1;
    cyc();
    if1.r_req = 0; if1.w_req = 0;
    checks++; if (if1.r_exc !== 1'b1 || if1.r_rdy !== 1'b0 || if1.r_line !== 32'h0) begin errors++; $display("FAIL t4_r_exc got=%b%b/%h exp=10/0", if1.r_exc, if1.r_rdy, if1.r_line); end
    checks++; if (if1.w_exc !== 1'b1 || if1.w_rdy !== 1'b0) begin errors++; $display("FAIL t4_w_exc got=%b%b exp=10", if1.w_exc, if1.w_rdy); end
    checks++; if (if1.exc_vld !== 1'b1 || if1.exc_addr !== 32'd1024) begin errors++; $display("FAIL t4_capture got=%b/%h exp=1/%h", if1.exc_vld, if1.exc_addr, 32'd1024); end
    if1.r_addr = 0; if1.r_req = 1;
    cyc();
    if1.r_req = 0;
    checks++; if (if1.r_line !== 32'hCAFEF00D) begin errors++; $display("FAIL t4_no_write got=%h exp=%h", if1.r_line, 32'hCAFEF00D); end
    checks++; if (if1.r_exc !== 1'b0 || if1.w_exc !== 1'b0) begin errors++; $display("FAIL t4_exc_pulse got=%b%b exp=00", if1.r_exc, if1.w_exc); end
    wr1(3000, 32'h1);
    checks++; if (if1.w_exc !== 1'b1 || if1.exc_addr !== 32'd1024) begin errors++; $display("FAIL t4_sticky got=%b/%h exp=1/%h", if1.w_exc, if1.exc_addr, 32'd1024); end
    if1.exc_clr = 1;
    cyc();
    if1.exc_clr = 0;
    checks++; if (if1.exc_vld !== 1'b0 || if1.exc_addr !== 32'h0) begin errors++; $display("FAIL t4_clear got=%b/%h exp=0/0", if1.exc_vld, if1.exc_addr); end
  endtask

  task automatic test_clr_set();
    if1.r_addr = 1500; if1.r_req = 1;
    cyc();
    if1.r_req = 0;
    checks++; if (if1.exc_vld !== 1'b1 || if1.exc_addr !== 32'd1500) begin errors++; $display("FAIL t5_first got=%b/%h exp=1/%h", if1.exc_vld, if1.exc_addr, 32'd1500); end
    if1.exc_clr = 1;
    if1.w_addr = 2000; if1.w_line = 32'h0; if1.w_be = 4'hF; if1.w_req = 1;
    cyc();
    if1.exc_clr = 0; if1.w_req = 0;
    checks++; if (if1.exc_vld !== 1'b1 || if1.exc_addr !== 32'd2000) begin errors++; $display("FAIL t5_set_beats_clr got=%b/%h exp=1/%h", if1.exc_vld, if1.exc_addr, 32'd2000); end
    if1.exc_clr = 1;
    cyc();
    if1.exc_clr = 0;
  endtask

  task automatic test_reset_midflight();
    wr2(9, 32'h5A5A1234);
    wr2(10, 32'h00C0FFEE);
    if2.r_addr = 9; if2.r_req = 1;
    cyc();
    if2.r_req = 0;
    rst_n = 0;
    #1;
    checks++; if (if2.r_rdy !== 1'b0 || if2.r_exc !== 1'b0 || if2.r_line !== 32'h0) begin errors++; $display("FAIL t6_async got=%b%b/%h exp=00/0", if2.r_rdy, if2.r_exc, if2.r_line); end
    if2.w_addr = 10; if2.w_line = 32'h00000BAD; if2.w_be = 4'hF; if2.w_req = 1;
    cyc();
    if2.w_req = 0;
    checks++; if (if2.r_rdy !== 1'b0 || if2.w_rdy !== 1'b0) begin errors++; $display("FAIL t6_in_reset got=%b%b exp=00", if2.r_rdy, if2.w_rdy); end
    rst_n = 1;
    cyc();
    checks++; if (if2.r_rdy !== 1'b0 || if2.r_exc !== 1'b0) begin errors++; $display("FAIL t6_dropped got=%b%b exp=00", if2.r_rdy, if2.r_exc); end
    if2.r_addr = 9; if2.r_req = 1;
    cyc();
    if2.r_addr = 10;
    cyc();
    if2.r_req = 0;
    checks++; if (if2.r_rdy !== 1'b1 || if2.r_line !== 32'h5A5A1234) begin errors++; $display("FAIL t6_kept got=%b/%h exp=1/%h", if2.r_rdy, if2.r_line, 32'h5A5A1234); end
    cyc();
    checks++; if (if2.r_rdy !== 1'b1 || if2.r_line !== 32'h00C0FFEE) begin errors++; $display("FAIL t6_no_reset_write got=%b/%h exp=1/%h", if2.r_rdy, if2.r_line, 32'h00C0FFEE); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    test_reset();
    test_write_read();
    test_write_first();
    test_pipeline();
    test_faults();
    test_clr_set();
    test_reset_midflight();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
